// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and address-field helpers for the instruction cache.
package icache_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 4;
    localparam int OFFSET_W   = $clog2(LINE_WORDS);
    localparam int INDEX_W    = $clog2(NUM_LINES);
    localparam int TAG_W      = WORD_SIZE - OFFSET_W - INDEX_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [WORD_SIZE-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [WORD_SIZE-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [WORD_SIZE-1:0] addr);
        return addr[WORD_SIZE-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational lookup, one-word fill write, line install and flush-all.
module icache_array
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INDEX_W-1:0]   rd_index,
    input  logic [OFFSET_W-1:0]  rd_offset,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [WORD_SIZE-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [OFFSET_W-1:0]  wr_offset,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 set_valid,
    input  logic [INDEX_W-1:0]   set_index,
    input  logic [TAG_W-1:0]     set_tag,
    input  logic                 flush_all
);

    logic [WORD_SIZE-1:0] data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[{wr_index, wr_offset}] <= wr_data;
        if (set_valid)
            tag_mem[set_index] <= set_tag;
    end

    // Flush wins over install so a line filled under a pending flush ends up invalid.
    always_ff @(posedge clk) begin
        if (reset)
            valid <= '0;
        else if (flush_all)
            valid <= '0;
        else if (set_valid)
            valid[set_index] <= 1'b1;
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped read-only I-cache: same-cycle hits, word-by-word line fill on miss, hit/miss stats.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(MEM_LATENCY);
    localparam logic [OFFSET_W-1:0] WORD_LAST = OFFSET_W'(LINE_WORDS - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [0:0]          state;
    logic [TAG_W-1:0]    base_tag;
    logic [INDEX_W-1:0]  base_index;
    logic [OFFSET_W-1:0] word_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic                flush_pending;
    logic                replay;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 hit;
    logic                 miss;
    logic                 sample;
    logic                 last_word;
    logic                 flush_all;

    assign hit       = (state == IDLE) && cpu_req && rd_valid && (rd_tag == addr_tag(cpu_addr));
    assign miss      = (state == IDLE) && cpu_req && !hit;
    assign sample    = (state == FILL) && (lat_cnt == LAT_LAST);
    assign last_word = sample && (word_cnt == WORD_LAST);
    assign flush_all = ((state == IDLE) && flush) || (last_word && (flush_pending || flush));

    assign cpu_ready = hit;
    assign cpu_rdata = hit ? rd_data : '0;
    // Address is held through the sample cycle; only mem_read drops so Memory rewinds its delay.
    assign mem_read  = (state == FILL) && (lat_cnt != LAT_LAST);
    assign mem_addr  = (state == FILL) ? {base_tag, base_index, word_cnt} : '0;

    icache_array u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (addr_index(cpu_addr)),
        .rd_offset (addr_offset(cpu_addr)),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (sample),
        .wr_index  (base_index),
        .wr_offset (word_cnt),
        .wr_data   (mem_rdata),
        .set_valid (last_word),
        .set_index (base_index),
        .set_tag   (base_tag),
        .flush_all (flush_all)
    );

    // Line base address is datapath state and only meaningful while in FILL.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && miss) begin
            base_tag   <= addr_tag(cpu_addr);
            base_index <= addr_index(cpu_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            word_cnt      <= '0;
            lat_cnt       <= '0;
            flush_pending <= 1'b0;
            replay        <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            // The first hit after a fill is the held request being replayed, not a new hit.
            replay <= last_word && cpu_req;
            case (state)
                IDLE: begin
                    if (miss) begin
                        word_cnt   <= '0;
                        lat_cnt    <= '0;
                        state      <= FILL;
                        miss_count <= sat_inc(miss_count);
                    end
                    if (hit && !replay)
                        hit_count <= sat_inc(hit_count);
                end
                default: begin
                    if (flush)
                        flush_pending <= 1'b1;
                    if (sample) begin
                        lat_cnt  <= '0;
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            state         <= IDLE;
                            flush_pending <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
